// File: rtl/vai_arb_pkg.sv
// Shared types and header-field helpers for the c1 burst arbiter.
package vai_arb_pkg;

  typedef enum logic {IDLE, BURST} t_arb_state;

  localparam int CL_LEN_LSB = 0;
  localparam int SOP_BIT    = 2;

  // cl_len 2 is reserved and degrades to a single-line burst.
  function automatic logic [2:0] burstLen(input logic [1:0] clLen);
    case (clLen)
      2'd1:    burstLen = 3'd2;
      2'd3:    burstLen = 3'd4;
      default: burstLen = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/vai_sidebuf_fifo.sv
// Per-port sidebuffer: show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module vai_sidebuf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     pClk,
  input  logic                     SoftReset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pClk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/vai_c1_burst_arbiter.sv
// Round-robin arbiter sharing the c1 write channel among sub-AFUs; multi-line bursts are never interleaved.
module vai_c1_burst_arbiter
  import vai_arb_pkg::*;
#(
  parameter int NUM_SUB_AFUS  = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFULL_SLACK = 8,
  parameter int HDR_W         = 80,
  parameter int DATA_W        = 512
) (
  input  logic                                     pClk,
  input  logic                                     SoftReset,
  input  logic [NUM_SUB_AFUS-1:0]                  in_valid,
  input  logic [NUM_SUB_AFUS-1:0][HDR_W-1:0]       in_hdr,
  input  logic [NUM_SUB_AFUS-1:0][DATA_W-1:0]      in_data,
  output logic [NUM_SUB_AFUS-1:0]                  in_almfull,
  input  logic                                     up_almfull,
  output logic                                     out_valid,
  output logic [HDR_W-1:0]                         out_hdr,
  output logic [DATA_W-1:0]                        out_data,
  output logic [$clog2(NUM_SUB_AFUS)-1:0]          out_port,
  output logic [NUM_SUB_AFUS-1:0]                  err_overflow,
  output logic [NUM_SUB_AFUS-1:0]                  err_protocol
);

  localparam int PW    = $clog2(NUM_SUB_AFUS);
  localparam int ENT_W = HDR_W + DATA_W;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ALMFULL_TH = CW'(FIFO_DEPTH - ALMFULL_SLACK);

  logic [NUM_SUB_AFUS-1:0]            fifoFull;
  logic [NUM_SUB_AFUS-1:0]            fifoEmpty;
  logic [NUM_SUB_AFUS-1:0]            popVec;
  logic [NUM_SUB_AFUS-1:0]            headSop;
  logic [NUM_SUB_AFUS-1:0]            eligible;
  logic [NUM_SUB_AFUS-1:0]            protoErr;
  logic [NUM_SUB_AFUS-1:0][CW-1:0]    fifoCount;
  logic [NUM_SUB_AFUS-1:0][ENT_W-1:0] fifoHead;

  t_arb_state     state;
  logic [PW-1:0]  rrPtr;
  logic [PW-1:0]  lockPort;
  logic [1:0]     beatsLeft;

  logic           issue;
  logic [PW-1:0]  issuePort;
  logic           startBurst;
  logic           discValid;
  logic [PW-1:0]  discPort;
  logic [ENT_W-1:0] selHead;
  logic [1:0]     selClLen;
  logic [2:0]     newLen;

  for (genvar gi = 0; gi < NUM_SUB_AFUS; gi++) begin : g_port
    vai_sidebuf_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .pClk      (pClk),
      .SoftReset (SoftReset),
      .push      (in_valid[gi]),
      .pop       (popVec[gi]),
      .din       ({in_hdr[gi], in_data[gi]}),
      .full      (fifoFull[gi]),
      .empty     (fifoEmpty[gi]),
      .count     (fifoCount[gi]),
      .head      (fifoHead[gi])
    );
    assign headSop[gi] = fifoHead[gi][DATA_W + SOP_BIT];
  end

  assign eligible = ~fifoEmpty & headSop;
  assign selHead  = fifoHead[issuePort];
  assign selClLen = selHead[DATA_W + CL_LEN_LSB +: 2];
  assign newLen   = burstLen(selClLen);

  always_comb begin
    int   idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    popVec     = '0;
    issue      = 1'b0;
    issuePort  = lockPort;
    startBurst = 1'b0;
    discValid  = 1'b0;
    discPort   = '0;
    if (state == IDLE) begin
      if (!up_almfull) begin
        for (int off = 1; off <= NUM_SUB_AFUS; off++) begin
          idx = int'(rrPtr) + off;
          if (idx >= NUM_SUB_AFUS) idx = idx - NUM_SUB_AFUS;
          if (!found && eligible[idx]) begin
            found     = 1'b1;
            issuePort = PW'(idx);
          end
        end
      end
      issue      = found;
      startBurst = found;
      // Orphan continuation beats are flushed lowest index first, one per cycle.
      for (int i = NUM_SUB_AFUS - 1; i >= 0; i--) begin
        if (!fifoEmpty[i] && !headSop[i]) begin
          discValid = 1'b1;
          discPort  = PW'(i);
        end
      end
    end else if (!up_almfull && !fifoEmpty[lockPort]) begin
      issue      = 1'b1;
      startBurst = headSop[lockPort];
    end
    if (issue)     popVec[issuePort] = 1'b1;
    if (discValid) popVec[discPort]  = 1'b1;
  end

  always_comb begin
    protoErr = '0;
    if (discValid) protoErr[discPort] = 1'b1;
    if (startBurst && (state == BURST || selClLen == 2'd2)) protoErr[issuePort] = 1'b1;
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      state        <= IDLE;
      rrPtr        <= '0;
      lockPort     <= '0;
      beatsLeft    <= '0;
      out_valid    <= 1'b0;
      out_hdr      <= '0;
      out_data     <= '0;
      out_port     <= '0;
      err_overflow <= '0;
      err_protocol <= '0;
      in_almfull   <= '0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        out_hdr  <= selHead[ENT_W-1 -: HDR_W];
        out_data <= selHead[DATA_W-1:0];
        out_port <= issuePort;
      end
      if (startBurst) begin
        lockPort  <= issuePort;
        rrPtr     <= issuePort;
        beatsLeft <= 2'(newLen - 3'd1);
        state     <= (newLen == 3'd1) ? IDLE : BURST;
      end else if (issue) begin
        beatsLeft <= beatsLeft - 2'd1;
        if (beatsLeft == 2'd1) state <= IDLE;
      end
      err_overflow <= err_overflow | (in_valid & fifoFull & ~popVec);
      err_protocol <= err_protocol | protoErr;
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        in_almfull[i] <= (fifoCount[i] >= ALMFULL_TH);
      end
    end
  end

endmodule

// File: tb/tb_vai_c1_burst_arbiter.sv
// Directed self-checking bench for the c1 burst arbiter.
module tb_vai_c1_burst_arbiter;

  localparam int N      = 9;
  localparam int HDR_W  = 80;
  localparam int DATA_W = 512;

  logic                     pClk = 1'b0;
  logic                     SoftReset;
  logic [N-1:0]             in_valid;
  logic [N-1:0][HDR_W-1:0]  in_hdr;
  logic [N-1:0][DATA_W-1:0] in_data;
  logic [N-1:0]             in_almfull;
  logic                     up_almfull;
  logic                     out_valid;
  logic [HDR_W-1:0]         out_hdr;
  logic [DATA_W-1:0]        out_data;
  logic [3:0]               out_port;
  logic [N-1:0]             err_overflow;
  logic [N-1:0]             err_protocol;

  int nCompared = 0;
  int nMismatched = 0;

  vai_c1_burst_arbiter dut (
    .pClk         (pClk),
    .SoftReset    (SoftReset),
    .in_valid     (in_valid),
    .in_hdr       (in_hdr),
    .in_data      (in_data),
    .in_almfull   (in_almfull),
    .up_almfull   (up_almfull),
    .out_valid    (out_valid),
    .out_hdr      (out_hdr),
    .out_data     (out_data),
    .out_port     (out_port),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  always #5 pClk = ~pClk;

  function automatic logic [HDR_W-1:0] mkHdr(input logic sop, input logic [1:0] cl, input logic [15:0] t);
    logic [HDR_W-1:0] h;
    h = '0;
    h[1:0]   = cl;
    h[2]     = sop;
    h[31:16] = ~t;
    h[79:64] = t;
    return h;
  endfunction

  function automatic logic [DATA_W-1:0] mkData(input logic [15:0] t);
    return {32{t}};
  endfunction

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic sop, input logic [1:0] cl, input logic [15:0] t);
    in_valid[p] = 1'b1;
    in_hdr[p]   = mkHdr(sop, cl, t);
    in_data[p]  = mkData(t);
  endtask

  task automatic expectBeat(input string tag, input int p, input logic sop, input logic [1:0] cl,
                            input logic [15:0] t);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".port"}, out_port, p);
    chk({tag, ".hdr"}, out_hdr, mkHdr(sop, cl, t));
    chk({tag, ".data"}, out_data, mkData(t));
  endtask

  initial begin
    int p;
    int j;
    SoftReset  = 1'b1;
    up_almfull = 1'b0;
    in_valid   = '0;
    in_hdr     = '0;
    in_data    = '0;
    tick();
    tick();
    chk("rst.valid", out_valid, 0);
    chk("rst.port", out_port, 0);
    chk("rst.almfull", in_almfull, 0);
    chk("rst.ovf", err_overflow, 0);
    chk("rst.proto", err_protocol, 0);
    SoftReset = 1'b0;

    // 1: single beat from port 3
    drive(3, 1'b1, 2'd0, 16'h0301);
    tick();
    in_valid = '0;
    chk("t1.early", out_valid, 0);
    tick();
    expectBeat("t1.beat", 3, 1'b1, 2'd0, 16'h0301);
    tick();
    chk("t1.after", out_valid, 0);

    // clear rr so the three-port rotation starts at port 1
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;

    // 3: ports 1,2,7 stream singles, 10 each
    for (int c = 0; c <= 30; c++) begin
      in_valid = '0;
      if (c < 10) begin
        drive(1, 1'b1, 2'd0, {8'd1, 8'(c)});
        drive(2, 1'b1, 2'd0, {8'd2, 8'(c)});
        drive(7, 1'b1, 2'd0, {8'd7, 8'(c)});
      end
      tick();
      if (c >= 1) begin
        j = c - 1;
        p = (j % 3 == 0) ? 1 : (j % 3 == 1) ? 2 : 7;
        expectBeat($sformatf("t3.b%0d", j), p, 1'b1, 2'd0, {8'(p), 8'(j / 3)});
      end
    end
    tick();
    chk("t3.idle", out_valid, 0);
    chk("t3.ovf", err_overflow, 0);

    // 2: ports 0 and 5 push 4-line bursts together; rr=7 so port 0 wins
    for (int c = 0; c <= 9; c++) begin
      in_valid = '0;
      if (c < 4) begin
        drive(0, c == 0, 2'd3, {8'h00, 8'(c)});
        drive(5, c == 0, 2'd3, {8'h05, 8'(c)});
      end
      tick();
      if (c >= 1 && c <= 8) begin
        j = c - 1;
        p = (j < 4) ? 0 : 5;
        expectBeat($sformatf("t2.b%0d", j), p, (j % 4) == 0, 2'd3, {8'(p), 8'(j % 4)});
      end else if (c == 9) begin
        chk("t2.idle", out_valid, 0);
      end
    end

    // 4: upstream hold mid-burst from port 4; port 1 waits behind it
    for (int c = 0; c <= 11; c++) begin
      in_valid = '0;
      if (c < 4) drive(4, c == 0, 2'd3, {8'h04, 8'(c)});
      if (c == 3) drive(1, 1'b1, 2'd0, 16'h01AA);
      up_almfull = (c >= 3 && c <= 7);
      tick();
      case (c)
        1:  expectBeat("t4.b0", 4, 1'b1, 2'd3, 16'h0400);
        2:  expectBeat("t4.b1", 4, 1'b0, 2'd3, 16'h0401);
        8:  expectBeat("t4.b2", 4, 1'b0, 2'd3, 16'h0402);
        9:  expectBeat("t4.b3", 4, 1'b0, 2'd3, 16'h0403);
        10: expectBeat("t4.p1", 1, 1'b1, 2'd0, 16'h01AA);
        default: chk($sformatf("t4.hold%0d", c), out_valid, 0);
      endcase
    end
    up_almfull = 1'b0;

    // 5: port 6 overfills while upstream is almost full
    up_almfull = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      in_valid = '0;
      drive(6, 1'b1, 2'd0, {8'h06, 8'(c)});
      tick();
      if (c == 7)  chk("t5.almf_lo", in_almfull, 0);
      if (c == 8)  chk("t5.almf_hi", in_almfull, 9'h040);
      if (c == 15) chk("t5.ovf_lo", err_overflow, 0);
      if (c == 16) chk("t5.ovf_hi", err_overflow, 9'h040);
      if (c == 16) chk("t5.noout", out_valid, 0);
    end
    in_valid   = '0;
    up_almfull = 1'b0;
    for (int d = 0; d < 16; d++) begin
      tick();
      expectBeat($sformatf("t5.d%0d", d), 6, 1'b1, 2'd0, {8'h06, 8'(d)});
    end
    tick();
    chk("t5.drained", out_valid, 0);
    chk("t5.almf_end", in_almfull, 0);
    chk("t5.ovf_sticky", err_overflow, 9'h040);

    // 6: reset right after the first beat of a port-4 burst
    up_almfull = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = '0;
      drive(4, c == 0, 2'd3, {8'h44, 8'(c)});
      tick();
    end
    in_valid   = '0;
    up_almfull = 1'b0;
    tick();
    expectBeat("t6.b0", 4, 1'b1, 2'd3, 16'h4400);
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
    chk("t6.rst.valid", out_valid, 0);
    chk("t6.rst.port", out_port, 0);
    chk("t6.rst.hdr", out_hdr, 0);
    chk("t6.rst.data", out_data, 0);
    chk("t6.rst.ovf", err_overflow, 0);
    chk("t6.rst.almf", in_almfull, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t6.silent%0d", c), out_valid, 0);
    end
    // rr back at 0: port 2 precedes port 0
    drive(0, 1'b1, 2'd0, 16'h00C0);
    drive(2, 1'b1, 2'd0, 16'h02C2);
    tick();
    in_valid = '0;
    tick();
    expectBeat("t6.p2", 2, 1'b1, 2'd0, 16'h02C2);
    tick();
    expectBeat("t6.p0", 0, 1'b1, 2'd0, 16'h00C0);
    tick();
    chk("t6.idle", out_valid, 0);

    // protocol errors: orphan beat, reserved cl_len, sop mid-burst
    drive(8, 1'b0, 2'd0, 16'h0808);
    tick();
    in_valid = '0;
    chk("t7.proto0", err_protocol, 0);
    tick();
    chk("t7.disc.proto", err_protocol, 9'h100);
    chk("t7.disc.valid", out_valid, 0);
    tick();
    chk("t7.disc.quiet", out_valid, 0);
    drive(7, 1'b1, 2'd2, 16'h0777);
    tick();
    in_valid = '0;
    tick();
    expectBeat("t7.cl2", 7, 1'b1, 2'd2, 16'h0777);
    chk("t7.cl2.proto", err_protocol, 9'h180);
    tick();
    chk("t7.cl2.single", out_valid, 0);
    drive(3, 1'b1, 2'd1, 16'h0331);
    tick();
    in_valid = '0;
    drive(3, 1'b1, 2'd0, 16'h0332);
    tick();
    in_valid = '0;
    expectBeat("t7.mid.a", 3, 1'b1, 2'd1, 16'h0331);
    tick();
    expectBeat("t7.mid.b", 3, 1'b1, 2'd0, 16'h0332);
    chk("t7.mid.proto", err_protocol, 9'h188);
    tick();
    chk("t7.mid.end", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/vai_c1_burst_arbiter.md
Name: vai_c1_burst_arbiter

Overview:
- Shares the single upstream CCI-P c1 (write-request) channel among NUM_SUB_AFUS sub-AFUs, between the Tx audit stage and the mux/manager path.
- Buffers each sub-AFU's write beats in a per-port sidebuffer FIFO and arbitrates round-robin.
- Never interleaves beats of a multi-line write burst.
- Honours upstream almost-full and drives per-port almost-full back to each sub-AFU.

Parameters:
- NUM_SUB_AFUS, 9, number of requesting ports.
- FIFO_DEPTH, 16, entries per port sidebuffer (power of 2).
- ALMFULL_SLACK, 8, port almost-full asserts when free entries <= ALMFULL_SLACK.
- HDR_W, 80, c1 request header width; header bits [1:0] = cl_len, bit [2] = sop.
- DATA_W, 512, write data width.

Ports:
- pClk  in  1  clock
- SoftReset  in  1  synchronous active-high reset
- in_valid  in  [NUM_SUB_AFUS]  per-port beat valid
- in_hdr  in  [NUM_SUB_AFUS][HDR_W]  per-port header
- in_data  in  [NUM_SUB_AFUS][DATA_W]  per-port data
- in_almfull  out  [NUM_SUB_AFUS]  per-port backpressure
- up_almfull  in  1  upstream c1 almost-full
- out_valid  out  1  upstream beat valid
- out_hdr  out  HDR_W  upstream header
- out_data  out  DATA_W  upstream data
- out_port  out  $clog2(NUM_SUB_AFUS)  source port of current beat
- err_overflow  out  [NUM_SUB_AFUS]  sticky overflow flag
- err_protocol  out  [NUM_SUB_AFUS]  sticky protocol-error flag

Behaviour:
- Reset (SoftReset sampled high at pClk edge; may occur at any cycle, including mid-burst):
  - all outputs 0; FIFOs emptied; state IDLE; rr pointer 0; err flags cleared.
  - Any burst in progress is abandoned; no partial beats are issued after reset.
- Push:
  - in_valid with FIFO not full -> write {hdr,data}.
  - in_valid with FIFO full -> beat dropped, err_overflow[i] set.
  - Simultaneous push and pop on a full FIFO is legal; the push is accepted.
- in_almfull[i] is registered: high the cycle after occupancy reaches FIFO_DEPTH-ALMFULL_SLACK.
- Burst length = 1 for cl_len 0, 2 for cl_len 1, 4 for cl_len 3. cl_len 2 is reserved: the beat is treated as a single-line burst and err_protocol[i] is set.
- FSM states: IDLE, BURST.
  - IDLE:
    - Eligible port: FIFO non-empty and head beat has sop=1.
    - If up_almfull=0 and any port is eligible: grant the first eligible port searching from rr+1 (wrapping at NUM_SUB_AFUS-1 -> 0), pop its head, load beats_left = len-1, set rr = grant.
    - If beats_left = 0 stay IDLE, else go to BURST.
    - A non-empty port whose head has sop=0 is popped and discarded without output, and err_protocol set. At most one such discard per cycle, lowest index first; the discard may occur in the same cycle as a grant to a different port.
  - BURST:
    - Each cycle with up_almfull=0 and the locked port non-empty: pop, decrement beats_left; when it reaches 0, go to IDLE.
    - up_almfull=1 or locked FIFO empty: hold, no pop, other ports are not granted.
    - A sop=1 beat encountered mid-burst ends the old burst (err_protocol set) and is treated as a new grant head.
- Output timing:
  - Registered; out_valid/out_hdr/out_data/out_port appear exactly 1 cycle after the pop.
  - Peak throughput 1 beat/cycle; back-to-back bursts from different ports have no bubble.
- up_almfull gating: sampled combinationally for the pop decision; an issue decision occurs only on cycles where up_almfull=0.

Decomposition:
- Shared package vai_arb_pkg:
  - t_arb_state enum {IDLE, BURST}.
  - Header field offsets (CL_LEN_LSB, SOP_BIT).
  - cl_len-to-length function.
- Sub-module vai_sidebuf_fifo: one instance per port.
  - Parameters: width, depth.
  - Signals: push, pop, full, empty, count, head.
  - Synchronous SoftReset.

Test Plan:
1. Port 3 sends one beat (cl_len 0, sop 1), up_almfull 0 -> out_valid high for 1 cycle, 2 cycles after in_valid, out_port=3, header/data identical.
2. Ports 0 and 5 each push a 4-line burst in the same cycle -> 8 consecutive out_valid beats; ports 0,0,0,0,5,5,5,5; no interleave; no bubble.
3. Ports 1, 2, 7 each continuously supply single beats -> out_port sequence 1,2,7,1,2,7...; no port starved over 30 cycles.
4. up_almfull asserted after beat 2 of a 4-line burst from port 4 for 5 cycles -> no out_valid during the hold (except the 1 already-popped beat); beats 3,4 follow, still port 4; no other port is granted meanwhile.
5. Port 6 pushes 17 beats while up_almfull=1 -> in_almfull[6] high once occupancy reaches 8; 17th beat dropped; err_overflow[6]=1; the 16 stored beats drain once up_almfull falls.
6. SoftReset for 1 cycle after beat 1 of a 4-line burst -> all outputs 0 the next cycle; the remaining 3 beats are never issued; a subsequent single beat from port 0 is issued normally with rr reset.
